// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter in front of a single-port synchronous memory.
//   Requester A (fetch) and requester B (load/store) each present one
//   transaction at a time; the winner is latched onto the memory port, the
//   memory samples it one edge later, and the read data is returned together
//   with a one-cycle ack for the owner. One transaction is started at most
//   every three cycles: IDLE -> ISSUE -> WAIT -> IDLE.
//
//   Configuration macro:
//     MEM_ARB_RR_EN  defined   : simultaneous requests are granted round-robin
//                                (A wins the first tie after reset).
//                    undefined : simultaneous requests always grant B; no
//                                pointer register exists.
//
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     a_req, a_we         requester A request / write enable
//     a_addr, a_wdata     requester A address / write data
//     a_ack               requester A completion pulse (1 cycle)
//     b_*                 requester B, same as A
//     rdata               read data, valid while a_ack or b_ack is high
//     mem_addr, mem_data  memory address / write data (held ISSUE..WAIT)
//     mem_we              memory write enable (high only during ISSUE)
//     mem_q               memory read data, one edge after mem_addr sampled
//     busy                high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0] state;
  logic       owner_b;   // 1: B owns the transaction in flight
  logic       grant_b;   // arbitration result, used only in IDLE
  logic       any_req;

  assign any_req = a_req | b_req;

`ifdef MEM_ARB_RR_EN
  logic rr_b_last;       // 1: B was granted last, so A wins the next tie

  // On a tie the requester that was not granted last wins.
  assign grant_b = b_req & (~a_req | ~rr_b_last);
`else
  // Fixed priority: B (load/store) beats A (fetch) on a tie.
  assign grant_b = b_req;
`endif

  assign busy = (state != S_IDLE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      owner_b  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      rdata    <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only in
      // the one state that needs them, which keeps them single-cycle.
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner_b  <= grant_b;
            mem_addr <= grant_b ? b_addr  : a_addr;
            mem_data <= grant_b ? b_wdata : a_wdata;
            mem_we   <= grant_b ? b_we    : a_we;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Memory samples addr/data/we at this edge; mem_we falls back to 0
          // via the default so the write happens exactly once.
          state <= S_WAIT;
        end
        S_WAIT: begin
          rdata <= mem_q;
          a_ack <= ~owner_b;
          b_ack <= owner_b;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_b_last <= 1'b1;
    end else if (state == S_IDLE && any_req) begin
      rr_b_last <= grant_b;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter with a small synchronous memory model.
//   Single-requester transactions come from a vector table; ties, hold-off,
//   abort-by-reset and reset values are hand-written sequences. A monitor
//   checks ack exclusivity and mem_we/busy consistency every cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, b_ack, mem_we, busy;
  logic [15:0] rdata, mem_addr, mem_data, mem_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .mem_q    (mem_q),
    .busy     (busy)
  );

  // Synchronous memory, 1K words, aliased on the low 10 address bits.
  logic        mem_clr;
  logic [15:0] mem [0:1023];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem_q <= 16'h0000;
    end else begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_data;
      mem_q <= mem[mem_addr[9:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Invariants checked on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack_exclusive", {30'd0, a_ack, b_ack} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
      check("we_implies_busy", (mem_we && !busy) ? 32'd1 : 32'd0, 32'd0);
    end
  end

  typedef struct {
    logic        sel_b;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        chk;
  } vec_t;

  vec_t vecs [10];

  task automatic clear_inputs();
    a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0; b_wdata = 16'h0;
  endtask

  // One isolated transaction from a single requester.
  task automatic run_txn(input vec_t v, input string tag);
    int we_cnt = 0;
    int lat    = 0;
    bit got    = 1'b0;
    @(negedge clk);
    if (v.sel_b) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (c == 1) begin
        check($sformatf("%s issue_busy", tag), {31'd0, busy}, 32'd1);
        check($sformatf("%s issue_addr", tag), {16'd0, mem_addr}, {16'd0, v.addr});
        if (v.we) check($sformatf("%s issue_data", tag), {16'd0, mem_data}, {16'd0, v.wdata});
        // Owner inputs change after the grant; the latched values must stay.
        if (v.sel_b) begin b_addr = ~v.addr; b_wdata = ~v.wdata; end
        else         begin a_addr = ~v.addr; a_wdata = ~v.wdata; end
      end
      if (c == 2) begin
        check($sformatf("%s wait_busy", tag), {31'd0, busy}, 32'd1);
        check($sformatf("%s wait_addr", tag), {16'd0, mem_addr}, {16'd0, v.addr});
      end
      if (a_ack || b_ack) begin
        got = 1'b1;
        lat = c;
      end
    end
    check($sformatf("%s latency", tag), lat, 3);
    check($sformatf("%s ack_a", tag), {31'd0, a_ack}, {31'd0, ~v.sel_b});
    check($sformatf("%s ack_b", tag), {31'd0, b_ack}, {31'd0, v.sel_b});
    check($sformatf("%s ack_busy", tag), {31'd0, busy}, 32'd0);
    check($sformatf("%s we_cycles", tag), we_cnt, {31'd0, v.we});
    if (v.chk) check($sformatf("%s rdata", tag), {16'd0, rdata}, {16'd0, v.exp_rdata});
    clear_inputs();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ack_cnt;
    int n;
    int order [4];
    int when  [4];
    bit got;
    int k;

    // Sequence hard-written expectations of the tie test.
`ifdef MEM_ARB_RR_EN
    int exp_order [4] = '{0, 1, 0, 1};
`else
    int exp_order [4] = '{1, 1, 1, 1};
`endif

    vecs[0] = '{1'b0, 1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 16'h03FF, 16'h4444, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'h4444, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 16'h0001, 16'h5A5A, 16'h0000, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h5A5A, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 16'hFC22, 16'h7777, 16'h0000, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 16'h7777, 1'b1};

    // Reset values with requests asserted: nothing may move.
    clear_inputs();
    rst_n   = 1'b0;
    mem_clr = 1'b1;
    a_req = 1'b1; a_addr = 16'h1234; b_req = 1'b1; b_addr = 16'h4321;
    repeat (3) @(negedge clk);
    check("rst busy",     {31'd0, busy},     32'd0);
    check("rst mem_we",   {31'd0, mem_we},   32'd0);
    check("rst mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst mem_data", {16'd0, mem_data}, 32'd0);
    check("rst a_ack",    {31'd0, a_ack},    32'd0);
    check("rst b_ack",    {31'd0, b_ack},    32'd0);
    check("rst rdata",    {16'd0, rdata},    32'd0);
    clear_inputs();
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // A requests during B's WAIT: held off, granted at the IDLE edge.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h03FF;
    @(negedge clk);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    @(negedge clk);
    check("holdoff b_ack",    {31'd0, b_ack},    32'd1);
    check("holdoff a_early",  {31'd0, a_ack},    32'd0);
    check("holdoff b_rdata",  {16'd0, rdata},    32'h4444);
    check("holdoff addr_keep", {16'd0, mem_addr}, 32'h03FF);
    b_req = 1'b0;
    got = 1'b0;
    k   = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (c == 1) check("holdoff addr_new", {16'd0, mem_addr}, 32'h0010);
      if (a_ack) begin got = 1'b1; k = c; end
    end
    check("holdoff a_latency", k, 3);
    check("holdoff a_rdata", {16'd0, rdata}, 32'hBEEF);
    clear_inputs();

    // Reset during ISSUE of a write aborts it.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0002; a_wdata = 16'h2222;
    @(negedge clk);
    check("abort pre_we", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort we_async",   {31'd0, mem_we},   32'd0);
    check("abort busy_async", {31'd0, busy},     32'd0);
    check("abort addr_async", {16'd0, mem_addr}, 32'd0);
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_ack || b_ack) ack_cnt++;
    end
    check("abort no_ack", ack_cnt, 0);
    run_txn('{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b1}, "abort_readback");

    // Both requesters held high for four reads, starting from a fresh pointer.
    pulse_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0000;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h03FF;
    n = 0;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        order[n] = b_ack ? 1 : 0;
        when[n]  = c;
        check($sformatf("tie%0d rdata", n), {16'd0, rdata},
              b_ack ? 32'h4444 : 32'h1111);
        n++;
      end
    end
    clear_inputs();
    check("tie count", n, 4);
    for (int i = 0; i < n; i++) begin
      check($sformatf("tie%0d owner", i), order[i], exp_order[i]);
      check($sformatf("tie%0d time", i), when[i], 3 * (i + 1));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
